// File: rtl/rr_grant_arbiter.sv
// Four-requester round-robin arbiter producing a registered grant index for a 2-to-4 decoder.
// Optional forced release after MAX_HOLD cycles when ARB_HOLD_LIMIT_EN is defined.
module rr_grant_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic [7:0] gnt_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic HOLD_EN = 1'b1;
`else
    localparam logic HOLD_EN = 1'b0;
`endif
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_n;
    logic [1:0] last, last_n;
    logic [7:0] hold_cnt, hold_cnt_n;
    logic [1:0] gnt_idx_n;
    logic       gnt_valid_n;
    logic [7:0] gnt_count_n;

    logic       hold_hit;
    logic       release_grant;
    logic [1:0] search_ptr;
    logic [2:0] pick;

    // Returns {found, index}; the candidate after ptr has highest priority, ptr itself lowest.
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 2'd3;
            hold_cnt  <= 8'd0;
            gnt_idx   <= 2'b00;
            gnt_valid <= 1'b0;
            gnt_count <= 8'd0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            hold_cnt  <= hold_cnt_n;
            gnt_idx   <= gnt_idx_n;
            gnt_valid <= gnt_valid_n;
            gnt_count <= gnt_count_n;
        end
    end

    always_comb begin
        hold_hit      = HOLD_EN && (hold_cnt == HOLD_LAST);
        release_grant = (state == GRANT) && (done || !req[gnt_idx] || hold_hit);
        // On release the pointer moves to the outgoing grantee before searching.
        search_ptr    = release_grant ? gnt_idx : last;
        pick          = rr_pick(search_ptr, req);
    end

    always_comb begin
        state_n     = state;
        last_n      = last;
        hold_cnt_n  = hold_cnt;
        gnt_idx_n   = gnt_idx;
        gnt_valid_n = gnt_valid;
        gnt_count_n = gnt_count;

        case (state)
            IDLE: begin
                if (pick[2]) begin
                    state_n     = GRANT;
                    gnt_idx_n   = pick[1:0];
                    gnt_valid_n = 1'b1;
                    gnt_count_n = gnt_count + 8'd1;
                    hold_cnt_n  = 8'd0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    last_n = gnt_idx;
                    if (pick[2]) begin
                        gnt_idx_n   = pick[1:0];
                        gnt_count_n = gnt_count + 8'd1;
                        hold_cnt_n  = 8'd0;
                    end else begin
                        state_n     = IDLE;
                        gnt_valid_n = 1'b0;
                    end
                end else begin
                    hold_cnt_n = sat_inc8(hold_cnt);
                end
            end
            default: begin
                state_n     = IDLE;
                gnt_valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed self-checking bench for rr_grant_arbiter; hold-limit expectations follow ARB_HOLD_LIMIT_EN.
module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic [7:0] gnt_count;

    int errors = 0;
    int checks = 0;

    rr_grant_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .gnt_count (gnt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] idx, input logic [7:0] cnt);
        chk({tag, "_valid"}, {7'd0, gnt_valid}, {7'd0, v});
        chk({tag, "_idx"}, {6'd0, gnt_idx}, {6'd0, idx});
        chk({tag, "_count"}, gnt_count, cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b0, 2'd0, 8'd0);
        rst = 1'b0;

        // No requests for 10 cycles
        for (int i = 0; i < 10; i++) tick();
        chk_out("idle10", 1'b0, 2'd0, 8'd0);

        // All request; done every third cycle -> 0,1,2,3,0 without bubbles
        req = 4'b1111;
        tick();
        chk_out("rr_g0", 1'b1, 2'd0, 8'd1);
        tick();
        tick();
        chk_out("rr_hold0", 1'b1, 2'd0, 8'd1);
        done = 1'b1; tick(); done = 1'b0;
        chk_out("rr_g1", 1'b1, 2'd1, 8'd2);
        tick(); tick();
        done = 1'b1; tick(); done = 1'b0;
        chk_out("rr_g2", 1'b1, 2'd2, 8'd3);
        tick(); tick();
        done = 1'b1; tick(); done = 1'b0;
        chk_out("rr_g3", 1'b1, 2'd3, 8'd4);
        tick(); tick();
        done = 1'b1; tick(); done = 1'b0;
        chk_out("rr_g0b", 1'b1, 2'd0, 8'd5);

        // Sole requester 2: withdrawal of 0 hands over, then done re-grants 2
        req = 4'b0100;
        tick();
        chk_out("sole_g2", 1'b1, 2'd2, 8'd6);
        done = 1'b1; tick();
        chk_out("sole_re1", 1'b1, 2'd2, 8'd7);
        tick(); done = 1'b0;
        chk_out("sole_re2", 1'b1, 2'd2, 8'd8);
        tick();
        chk_out("sole_stable", 1'b1, 2'd2, 8'd8);
        req = 4'b0000;
        tick();
        chk_out("sole_drop", 1'b0, 2'd2, 8'd8);

        // Withdrawal chain 1 -> 3 -> idle
        do_reset();
        chk_out("wd_reset", 1'b0, 2'd0, 8'd0);
        req = 4'b0010;
        tick();
        chk_out("wd_g1", 1'b1, 2'd1, 8'd1);
        req = 4'b1010;
        tick();
        chk_out("wd_other_bit", 1'b1, 2'd1, 8'd1);
        req = 4'b1000;
        tick();
        chk_out("wd_g3", 1'b1, 2'd3, 8'd2);
        req = 4'b0000;
        tick();
        chk_out("wd_idle", 1'b0, 2'd3, 8'd2);

        // Hold limit behaviour with req=0011 and no done
        do_reset();
        req = 4'b0011;
        tick();
        chk_out("hold_g0", 1'b1, 2'd0, 8'd1);
`ifdef ARB_HOLD_LIMIT_EN
        tick(); tick(); tick();
        chk_out("hold_pre", 1'b1, 2'd0, 8'd1);
        tick();
        chk_out("hold_g1", 1'b1, 2'd1, 8'd2);
        tick(); tick(); tick();
        chk_out("hold_pre1", 1'b1, 2'd1, 8'd2);
        tick();
        chk_out("hold_g0b", 1'b1, 2'd0, 8'd3);
`else
        for (int i = 0; i < 12; i++) tick();
        chk_out("hold_none", 1'b1, 2'd0, 8'd1);
`endif

        // Reset mid-grant with index 2 active
        do_reset();
        req = 4'b0100;
        tick();
        chk_out("mid_g2", 1'b1, 2'd2, 8'd1);
        req = 4'b1111;
        rst = 1'b1;
        tick();
        chk_out("mid_rst", 1'b0, 2'd0, 8'd0);
        rst = 1'b0;
        tick();
        chk_out("mid_after", 1'b1, 2'd0, 8'd1);

        // done and withdrawal together are one release
        done = 1'b1;
        req  = 4'b1110;
        tick();
        done = 1'b0;
        chk_out("dual_rel", 1'b1, 2'd1, 8'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
